pipe_add: RTL and testbench



---
 rtl/pipe_add_pkg.sv | 17 +
 rtl/pipe_add_add_seg.sv | 30 +++
 rtl/pipe_add.sv | 136 +++++++++++++
 tb/tb_pipe_add.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_add_pkg.sv
// Shared defaults and the per-stage control record for pipe_add.
// PIPE_ADD_SUB_EN adds the subtract-select bit to the record.
package pipe_add_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
`ifdef PIPE_ADD_SUB_EN
        logic sub;
`endif
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_add_add_seg.sv
// Combinational SEG-bit ripple adder; also exposes the carry into its MSB
// so the top segment can derive signed overflow.
module add_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb_in
);

    logic [SEG:0] c_s;

    // Bit-serial carry chain.
    always_comb begin
        c_s    = '0;
        sum    = '0;
        c_s[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c_s[SEG];
    assign c_msb_in = c_s[SEG-1];

endmodule

// File: rtl/pipe_add.sv
// Pipelined carry-segmented adder with valid/ready handshake.
// Defining PIPE_ADD_SUB_EN adds in_sub (A - B via inverted B and forced carry-in).
module pipe_add
    import pipe_add_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPE_ADD_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_cfg_check
        $error("pipe_add: WIDTH must be a non-zero multiple of STAGES");
    end

    stage_t         entry_s;
    stage_t         src_s      [STAGES];
    stage_t         st_d       [STAGES];
    stage_t         st_q       [STAGES];
    logic [SEG-1:0] seg_sum_s  [STAGES];
    logic           seg_cout_s [STAGES];
    logic           seg_cmsb_s [STAGES];
    logic           adv_s;
    logic           unused_s;

    // The whole pipe moves together; it only stalls when a result is waiting.
    assign adv_s    = !st_q[LAST].ctrl.valid || out_ready;
    assign in_ready = adv_s;

    // Operand record entering stage 0, with subtract folded into B and carry-in.
    always_comb begin
        entry_s            = '0;
        entry_s.ctrl.valid = in_valid;
        entry_s.a          = in_a;
`ifdef PIPE_ADD_SUB_EN
        entry_s.ctrl.sub   = in_sub;
        if (in_sub) begin
            entry_s.b          = ~in_b;
            entry_s.ctrl.carry = 1'b1;
        end else begin
            entry_s.b          = in_b;
            entry_s.ctrl.carry = in_cin;
        end
`else
        entry_s.b          = in_b;
        entry_s.ctrl.carry = in_cin;
`endif
    end

    // Each stage works on the record held by the stage before it.
    always_comb begin
        src_s[0] = entry_s;
        for (int k = 1; k < STAGES; k++) begin
            src_s[k] = st_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        add_seg #(
            .SEG (SEG)
        ) u_seg (
            .a        (src_s[g].a[g*SEG +: SEG]),
            .b        (src_s[g].b[g*SEG +: SEG]),
            .cin      (src_s[g].ctrl.carry),
            .sum      (seg_sum_s[g]),
            .cout     (seg_cout_s[g]),
            .c_msb_in (seg_cmsb_s[g])
        );
    end

    // Next stage contents: fill in this stage's sum segment and outgoing carry.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            st_d[k] = st_q[k];
            if (adv_s) begin
                st_d[k]                   = src_s[k];
                st_d[k].sum[k*SEG +: SEG] = seg_sum_s[k];
                st_d[k].ctrl.carry        = seg_cout_s[k];
                st_d[k].ctrl.ovf          = seg_cmsb_s[k] ^ seg_cout_s[k];
            end else begin
                st_d[k] = st_q[k];
            end
        end
    end

    // Stage registers; reset flushes every in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= st_d[k];
            end
        end
    end

    assign out_valid = st_q[LAST].ctrl.valid;
    assign out_sum   = st_q[LAST].sum;
    assign out_cout  = st_q[LAST].ctrl.carry;
    assign out_ovf   = st_q[LAST].ctrl.ovf;

    // Consumed operand segments and per-stage ovf bits are intentionally dropped.
    always_comb begin
        unused_s = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            unused_s = unused_s ^ (^st_q[k]);
        end
    end

endmodule

// File: tb/tb_pipe_add.sv
// Self-checking bench for pipe_add (WIDTH=8, STAGES=2) with a plain-arithmetic
// reference model; subtract scenarios compile in with PIPE_ADD_SUB_EN.
module tb_pipe_add;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_cin    = 1'b0;
`ifdef PIPE_ADD_SUB_EN
    logic         in_sub    = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    pipe_add #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef PIPE_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from integer arithmetic on the operand values.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
        int ua, ub, c, us, sa, sb, ss;
        ua = int'(a);
        ub = sub ? (255 - int'(b)) : int'(b);
        c  = sub ? 1 : int'(cin);
        us = ua + ub + c;
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        ss = sa + sb + c;
        return {((ss > 127) || (ss < -128)) ? 1'b1 : 1'b0,
                (us >= 256) ? 1'b1 : 1'b0,
                8'(us % 256)};
    endfunction

    task automatic drive_op(input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic sub);
        in_a   = a;
        in_b   = b;
        in_cin = cin;
`ifdef PIPE_ADD_SUB_EN
        in_sub = sub;
`endif
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_op(8'h00, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got=%h exp=00", out_sum); end
        n_cmp++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", out_cout); end
        n_cmp++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single(input string name, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic sub);
        int         lat;
        logic [9:0] exp_v;
        logic [9:0] got_v;
        exp_v = model(a, b, cin, sub);
        @(negedge clk);
        drive_op(a, b, cin, sub);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept in_ready=%b exp=1", name, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != S) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, S); end
        got_v = {out_ovf, out_cout, out_sum};
        n_cmp++; if (got_v !== exp_v) begin n_fail++; $display("FAIL %s_result got={ovf,cout,sum}=%h exp=%h", name, got_v, exp_v); end
    endtask

    // Handshaked stream against a queue of model results; reports the longest
    // run of consecutive output transfers.
    task automatic run_stream(input string name, input int n_ops, input int p_valid,
                              input int p_ready, input bit directed, output int max_run);
        logic [9:0] q[$];
        logic [9:0] exp_v;
        logic [9:0] got_v;
        logic [7:0] a_v, b_v;
        logic       c_v, s_v;
        int         sent = 0, got = 0, cyc = 0, run = 0;
        max_run = 0;
        while ((sent < n_ops || q.size() != 0) && cyc < n_ops * 20 + 50) begin
            @(negedge clk);
            cyc++;
            if (directed) begin
                a_v = 8'(sent);
                b_v = 8'(16 * sent);
                c_v = 1'b0;
            end else begin
                a_v = 8'($urandom);
                b_v = 8'($urandom);
                c_v = 1'($urandom_range(1));
            end
            s_v = 1'b0;
`ifdef PIPE_ADD_SUB_EN
            if (!directed) s_v = 1'($urandom_range(1));
`endif
            drive_op(a_v, b_v, c_v, s_v);
            in_valid  = (sent < n_ops) && ($urandom_range(99) < p_valid);
            out_ready = ($urandom_range(99) < p_ready);
            #1;
            if (out_valid && out_ready) begin
                got_v = {out_ovf, out_cout, out_sum};
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL %s_unexpected got=%h with empty queue", name, got_v);
                end else begin
                    exp_v = q.pop_front();
                    if (got_v !== exp_v) begin n_fail++; $display("FAIL %s_result[%0d] got=%h exp=%h", name, got, got_v, exp_v); end
                end
                got++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a_v, b_v, c_v, s_v));
                sent++;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (got != n_ops) begin n_fail++; $display("FAIL %s_count got=%0d exp=%0d", name, got, n_ops); end
    endtask

    task automatic test_back_to_back();
        int max_run;
        run_stream("b2b", 8, 100, 100, 1'b1, max_run);
        n_cmp++; if (max_run != 8) begin n_fail++; $display("FAIL b2b_consecutive got=%0d exp=8", max_run); end
    endtask

    task automatic test_random();
        int max_run;
        run_stream("rand", 200, 70, 60, 1'b0, max_run);
    endtask

    task automatic test_stall();
        logic [7:0] av [3];
        logic [7:0] bv [3];
        logic [9:0] q[$];
        logic [9:0] held, exp_v, got_v;
        int         idx = 0, cyc = 0, n_out = 0;
        bit         have_held = 1'b0;
        held = '0;
        for (int i = 0; i < 3; i++) begin
            av[i] = 8'($urandom);
            bv[i] = 8'($urandom);
        end
        while ((idx < 3 || q.size() != 0) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            out_ready = (cyc > 5);
            if (idx < 3) begin
                drive_op(av[idx], bv[idx], 1'b0, 1'b0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            got_v = {out_ovf, out_cout, out_sum};
            if (cyc >= 3 && cyc <= 5) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=1", cyc, out_valid); end
                if (have_held) begin
                    n_cmp++; if (got_v !== held) begin n_fail++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc, got_v, held); end
                end
                held      = got_v;
                have_held = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL stall_unexpected got=%h with empty queue", got_v);
                end else begin
                    exp_v = q.pop_front();
                    if (got_v !== exp_v) begin n_fail++; $display("FAIL stall_result[%0d] got=%h exp=%h", n_out, got_v, exp_v); end
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(av[idx], bv[idx], 1'b0, 1'b0));
                idx++;
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (n_out != 3) begin n_fail++; $display("FAIL stall_count got=%0d exp=3", n_out); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        drive_op(8'($urandom_range(100, 1)), 8'($urandom_range(100, 1)), 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drive_op(8'($urandom_range(100, 1)), 8'($urandom_range(100, 1)), 1'b0, 1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        n_cmp++; if (out_sum !== 8'h00) begin n_fail++; $display("FAIL midrst_sum got=%h exp=00", out_sum); end
        n_cmp++; if ({out_cout, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags got=%b exp=00", {out_cout, out_ovf}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale cyc=%0d got=%b exp=0", i, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "tb_pipe_add watchdog");
    end

    initial begin
        test_reset();
        test_single("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        test_single("7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0);
        test_single("80_plus_80", 8'h80, 8'h80, 1'b1, 1'b0);
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midstream();
        test_single("after_reset", 8'h12, 8'h34, 1'b1, 1'b0);
`ifdef PIPE_ADD_SUB_EN
        test_single("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1);
        test_single("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1);
`endif
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
